sweep_peak_register: RTL and testbench

//  Sweep controller and peak store on the far side of the voltage comparator's GT interface.
//  - Steps the servo position from 0 to POS_MAX.
//  - At each step, waits a settle time, captures one ADC sample and presents it as PV.
//  - On GT from the comparator, stores that sample as the new LV and its position as BEST_POS.
//  - At sweep end, parks the servo at BEST_POS and pulses DONE.
//  - Sits between the ADC front end, voltage comparator and servo PWM generator.

---
 rtl/sweep_peak_register_pkg.sv | 25 ++
 rtl/sweep_peak_register_settle_timer.sv | 30 +++
 rtl/sweep_peak_register.sv | 121 ++++++++++++
 tb/tb_sweep_peak_register.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_peak_register_pkg.sv
// Shared constants for the sweep/peak path: default widths used by the comparator
// and servo blocks, plus the sweep controller state encoding.
package sweep_peak_register_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned POS_W_DEF  = 8;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_SETTLE  = 3'd1;
  localparam logic [STATE_W-1:0] S_SAMPLE  = 3'd2;
  localparam logic [STATE_W-1:0] S_COMPARE = 3'd3;
  localparam logic [STATE_W-1:0] S_DECIDE  = 3'd4;
  localparam logic [STATE_W-1:0] S_FINISH  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = S_IDLE,
    ST_SETTLE  = S_SETTLE,
    ST_SAMPLE  = S_SAMPLE,
    ST_COMPARE = S_COMPARE,
    ST_DECIDE  = S_DECIDE,
    ST_FINISH  = S_FINISH
  } state_t;

endpackage

// File: rtl/sweep_peak_register_settle_timer.sv
// Settle timer: cleared by load, counts while enabled, flags expiry on the
// last count and wraps to zero so the next settle period starts clean.
module sweep_peak_register_settle_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned     CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign expire_c = en && (cnt == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load || expire_c) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sweep_peak_register.sv
// Sweep controller and peak store: steps the servo, samples the ADC after each
// settle, keeps the sample the comparator flags as larger, then parks at the peak.
module sweep_peak_register
  import sweep_peak_register_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned POS_W      = POS_W_DEF,
  parameter int unsigned POS_MAX    = 180,
  parameter int unsigned SETTLE_CYC = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              ADC_VALID,
  input  logic              GT,
  output logic [DATA_W-1:0] PV,
  output logic [DATA_W-1:0] LV,
  output logic [POS_W-1:0]  POS,
  output logic [POS_W-1:0]  BEST_POS,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX);

  state_t            state, state_nx;
  logic [DATA_W-1:0] pv_nx, lv_nx;
  logic [POS_W-1:0]  pos_nx, best_nx;
  logic              busy_nx, done_nx;
  logic              tmr_load, tmr_en, tmr_expire_c;

  sweep_peak_register_settle_timer #(
    .CYCLES (SETTLE_CYC)
  ) u_settle (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .en       (tmr_en),
    .expire_c (tmr_expire_c)
  );

  // State and all output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      PV       <= '0;
      LV       <= '0;
      POS      <= '0;
      BEST_POS <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nx;
      PV       <= pv_nx;
      LV       <= lv_nx;
      POS      <= pos_nx;
      BEST_POS <= best_nx;
      BUSY     <= busy_nx;
      DONE     <= done_nx;
    end
  end

  // Next state and datapath; PV/LV hold unless explicitly loaded
  always_comb begin
    state_nx = state;
    pv_nx    = PV;
    lv_nx    = LV;
    pos_nx   = POS;
    best_nx  = BEST_POS;
    busy_nx  = BUSY;
    done_nx  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (START) begin
          lv_nx    = '0;
          best_nx  = '0;
          pos_nx   = '0;
          busy_nx  = 1'b1;
          tmr_load = 1'b1;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_expire_c) state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (ADC_VALID) begin
          pv_nx    = ADC_DATA;
          state_nx = ST_COMPARE;
        end
      end
      ST_COMPARE: state_nx = ST_DECIDE;
      ST_DECIDE: begin
        // GT was registered by the comparator from this PV/LV pair
        if (GT) begin
          lv_nx   = PV;
          best_nx = POS;
        end
        if (POS >= POS_LAST) begin
          state_nx = ST_FINISH;
        end else begin
          pos_nx   = POS + POS_W'(1);
          state_nx = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        pos_nx   = BEST_POS;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sweep_peak_register.sv
// Bench for sweep_peak_register: drives directed sweeps against a comparator
// model and checks every output each cycle against a timeline model.
module tb_sweep_peak_register;

  localparam int DW   = 12;
  localparam int PW   = 8;
  localparam int PMAX = 7;
  localparam int SCYC = 4;
  localparam int SH   = DW - 6;

  logic          CLK, RST, START, ADC_VALID, GT;
  logic [DW-1:0] ADC_DATA, PV, LV;
  logic [PW-1:0] POS, BEST_POS;
  logic          BUSY, DONE;

  logic          gt_reg, gt_inject;
  logic [DW-1:0] exp_pv, exp_lv;
  logic [PW-1:0] exp_pos, exp_best;
  logic          exp_busy, exp_done;

  logic [DW-1:0] samp [PMAX+1];
  int            dly  [PMAX+1];
  int            n_cmp, n_fail, busy_cyc, done_cnt, b0, d0;

  sweep_peak_register #(
    .DATA_W     (DW),
    .POS_W      (PW),
    .POS_MAX    (PMAX),
    .SETTLE_CYC (SCYC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .ADC_DATA  (ADC_DATA),
    .ADC_VALID (ADC_VALID),
    .GT        (GT),
    .PV        (PV),
    .LV        (LV),
    .POS       (POS),
    .BEST_POS  (BEST_POS),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Comparator: strict greater-than on the upper 6 bits, registered
  always_ff @(posedge CLK) gt_reg <= (PV >> SH) > (LV >> SH);
  assign GT = gt_reg | gt_inject;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_exp();
    exp_pv = '0; exp_lv = '0; exp_pos = '0; exp_best = '0;
    exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  // Timeline model of one sweep; abort_pos >= 0 pulses reset mid-settle there
  task automatic run_sweep(input bit noise, input int abort_pos);
    START = 1'b1;
    step_clk();
    START = 1'b0;
    exp_busy = 1'b1; exp_pos = '0; exp_lv = '0; exp_best = '0; exp_done = 1'b0;
    for (int p = 0; p <= PMAX; p++) begin
      for (int c = 0; c < SCYC; c++) begin
        if (p == abort_pos && c == 2) begin
          RST = 1'b1;
          clear_exp();
          #2;
          check("rst_async_pv", 32'(PV), 0);
          check("rst_async_lv", 32'(LV), 0);
          check("rst_async_pos", 32'(POS), 0);
          check("rst_async_best", 32'(BEST_POS), 0);
          check("rst_async_busy", 32'(BUSY), 0);
          check("rst_async_done", 32'(DONE), 0);
          step_clk();
          RST = 1'b0;
          return;
        end
        if (noise) begin
          ADC_VALID = (c % 2 == 0);
          ADC_DATA  = DW'(12'hFFF);
          START     = 1'b1;
          gt_inject = 1'b1;
        end
        step_clk();
      end
      ADC_VALID = 1'b0; START = 1'b0; gt_inject = 1'b0;
      for (int w = 0; w < dly[p]; w++) begin
        ADC_DATA = DW'(w * 37 + 5);
        step_clk();
      end
      ADC_DATA  = samp[p];
      ADC_VALID = 1'b1;
      step_clk();
      ADC_VALID = 1'b0;
      exp_pv = samp[p];
      step_clk();
      step_clk();
      if ((samp[p] >> SH) > (exp_lv >> SH)) begin
        exp_lv   = samp[p];
        exp_best = PW'(p);
      end
      if (p < PMAX) exp_pos = PW'(p + 1);
    end
    step_clk();
    exp_pos = exp_best; exp_done = 1'b1; exp_busy = 1'b0;
    step_clk();
    exp_done = 1'b0;
  endtask

  // Per-cycle compare against the model
  initial begin : compare
    forever begin
      @(negedge CLK);
      check("pv", 32'(PV), 32'(exp_pv));
      check("lv", 32'(LV), 32'(exp_lv));
      check("pos", 32'(POS), 32'(exp_pos));
      check("best_pos", 32'(BEST_POS), 32'(exp_best));
      check("busy", 32'(BUSY), 32'(exp_busy));
      check("done", 32'(DONE), 32'(exp_done));
      if (BUSY === 1'b1) busy_cyc++;
      if (DONE === 1'b1) done_cnt++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    n_cmp = 0; n_fail = 0; busy_cyc = 0; done_cnt = 0;
    RST = 1'b1; START = 1'b0; ADC_VALID = 1'b0; ADC_DATA = '0; gt_inject = 1'b0;
    clear_exp();
    for (int i = 0; i <= PMAX; i++) dly[i] = 0;
    repeat (2) step_clk();
    RST = 1'b0;
    repeat (3) step_clk();

    // Mixed readings with a coarse tie (950 vs 900) that must not win
    samp = '{100, 900, 400, 900, 200, 950, 63, 0};
    b0 = busy_cyc; d0 = done_cnt;
    run_sweep(1'b0, -1);
    check("mix_lv", 32'(LV), 900);
    check("mix_best", 32'(BEST_POS), 1);
    check("mix_pos_park", 32'(POS), 1);
    check("mix_busy_cycles", 32'(busy_cyc - b0), 57);
    check("mix_done_pulses", 32'(done_cnt - d0), 1);
    repeat (3) step_clk();

    // Monotonic ramp: last position wins
    for (int i = 0; i <= PMAX; i++) samp[i] = DW'(i * 64);
    d0 = done_cnt;
    run_sweep(1'b0, -1);
    check("ramp_lv", 32'(LV), 448);
    check("ramp_best", 32'(BEST_POS), 7);
    check("ramp_pos_park", 32'(POS), 7);
    check("ramp_done_pulses", 32'(done_cnt - d0), 1);
    repeat (2) step_clk();

    // START, ADC_VALID and GT noise during settle must be ignored
    samp = '{100, 900, 400, 900, 200, 950, 63, 0};
    b0 = busy_cyc; d0 = done_cnt;
    run_sweep(1'b1, -1);
    check("noise_lv", 32'(LV), 900);
    check("noise_best", 32'(BEST_POS), 1);
    check("noise_busy_cycles", 32'(busy_cyc - b0), 57);
    check("noise_done_pulses", 32'(done_cnt - d0), 1);
    repeat (2) step_clk();

    // Late ADC strobe: holds in SAMPLE, result unchanged
    dly[2] = 50;
    b0 = busy_cyc; d0 = done_cnt;
    run_sweep(1'b0, -1);
    dly[2] = 0;
    check("late_lv", 32'(LV), 900);
    check("late_best", 32'(BEST_POS), 1);
    check("late_busy_cycles", 32'(busy_cyc - b0), 107);
    check("late_done_pulses", 32'(done_cnt - d0), 1);
    repeat (2) step_clk();

    // Reset mid-settle at position 5 aborts without DONE
    for (int i = 0; i <= PMAX; i++) samp[i] = DW'(i * 64);
    d0 = done_cnt;
    run_sweep(1'b0, 5);
    repeat (4) step_clk();
    check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_busy_low", 32'(BUSY), 0);

    // All-zero sweep after abort: nothing stored, parks at 0
    for (int i = 0; i <= PMAX; i++) samp[i] = '0;
    b0 = busy_cyc; d0 = done_cnt;
    run_sweep(1'b0, -1);
    check("zero_lv", 32'(LV), 0);
    check("zero_best", 32'(BEST_POS), 0);
    check("zero_pos_park", 32'(POS), 0);
    check("zero_busy_cycles", 32'(busy_cyc - b0), 57);
    check("zero_done_pulses", 32'(done_cnt - d0), 1);
    repeat (3) step_clk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
